// File: rtl/data_skew_buffer.sv
// data_skew_buffer: systolic-array edge buffer that skews or deskews DATA_NUM
// signed lanes by a per-lane multiple of SKEW_STEP enabled cycles, with three
// control tags delayed by the full MAX_DLY depth, stall gating, synchronous flush
// and a mode register that only changes while nothing is in flight.
module data_skew_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_NUM   = 16,
    parameter int SKEW_STEP  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic                         mode_i,
    input  logic signed [DATA_WIDTH-1:0] data_in  [DATA_NUM],
    output logic signed [DATA_WIDTH-1:0] data_out [DATA_NUM],
    input  logic                         input_valid_i,
    input  logic                         calc_done_i,
    input  logic                         is_init_data_i,
    output logic                         input_valid_o,
    output logic                         calc_done_o,
    output logic                         is_init_data_o,
    output logic                         mode_o,
    output logic                         busy_o
);

    localparam int MAX_DLY = (DATA_NUM - 1) * SKEW_STEP;

    logic mode_q;

    // Mode only switches while the pipeline is empty and no beat is entering,
    // so a lane's tap never moves under data that is already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
        end else if (!busy_o && !input_valid_i && !flush_i) begin
            mode_q <= mode_i;
        end
    end

    assign mode_o = mode_q;

    if (MAX_DLY > 0) begin : g_dly
        // lane_q[i][k] holds lane i delayed by k+1 enabled cycles.
        logic signed [DATA_WIDTH-1:0] lane_q [DATA_NUM][MAX_DLY];
        logic [MAX_DLY-1:0]           valid_q;
        logic [MAX_DLY-1:0]           done_q;
        logic [MAX_DLY-1:0]           init_q;

        // Lane and tag shift chains: reset/flush clear everything, en_i advances.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DATA_NUM; i++) begin
                    for (int k = 0; k < MAX_DLY; k++) begin
                        lane_q[i][k] <= '0;
                    end
                end
                valid_q <= '0;
                done_q  <= '0;
                init_q  <= '0;
            end else if (flush_i) begin
                for (int i = 0; i < DATA_NUM; i++) begin
                    for (int k = 0; k < MAX_DLY; k++) begin
                        lane_q[i][k] <= '0;
                    end
                end
                valid_q <= '0;
                done_q  <= '0;
                init_q  <= '0;
            end else if (en_i) begin
                for (int i = 0; i < DATA_NUM; i++) begin
                    lane_q[i][0] <= data_in[i];
                    for (int k = 1; k < MAX_DLY; k++) begin
                        lane_q[i][k] <= lane_q[i][k-1];
                    end
                end
                valid_q[0] <= input_valid_i;
                done_q[0]  <= calc_done_i;
                init_q[0]  <= is_init_data_i;
                for (int k = 1; k < MAX_DLY; k++) begin
                    valid_q[k] <= valid_q[k-1];
                    done_q[k]  <= done_q[k-1];
                    init_q[k]  <= init_q[k-1];
                end
            end
        end

        // Each lane has two fixed taps; the mode register picks one.
        for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
            localparam int DS = i * SKEW_STEP;
            localparam int DD = (DATA_NUM - 1 - i) * SKEW_STEP;
            logic signed [DATA_WIDTH-1:0] tap_skew;
            logic signed [DATA_WIDTH-1:0] tap_deskew;

            if (DS == 0) begin : g_s0
                assign tap_skew = data_in[i];
            end else begin : g_sn
                assign tap_skew = lane_q[i][DS-1];
            end

            if (DD == 0) begin : g_d0
                assign tap_deskew = data_in[i];
            end else begin : g_dn
                assign tap_deskew = lane_q[i][DD-1];
            end

            assign data_out[i] = mode_q ? tap_deskew : tap_skew;
        end

        assign input_valid_o  = valid_q[MAX_DLY-1];
        assign calc_done_o    = done_q[MAX_DLY-1];
        assign is_init_data_o = init_q[MAX_DLY-1];
        assign busy_o         = |valid_q;
    end else begin : g_pass
        // Single lane: no delay stages at all, everything is a wire.
        for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
            assign data_out[i] = data_in[i];
        end

        assign input_valid_o  = input_valid_i;
        assign calc_done_o    = calc_done_i;
        assign is_init_data_o = is_init_data_i;
        assign busy_o         = 1'b0;
    end

endmodule

// File: tb/tb_data_skew_buffer.sv
// Testbench for data_skew_buffer: two instances (4 lanes/step 1 and 3 lanes/step 2)
// share one control stream; every cycle both are compared to a beat-log model.
module tb_data_skew_buffer;

    localparam int W    = 16;
    localparam int NA   = 4;
    localparam int SA   = 1;
    localparam int MA   = (NA - 1) * SA;
    localparam int NB   = 3;
    localparam int SB   = 2;
    localparam int MB   = (NB - 1) * SB;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst, en, flush, mode_in, v_in, c_in, i_in;
    logic signed [W-1:0] din    [NA];
    logic signed [W-1:0] din_b  [NB];
    logic signed [W-1:0] dout_a [NA];
    logic signed [W-1:0] dout_b [NB];
    logic va, ca, ia, ma, ba;
    logic vb, cb, ib, mb, bb;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NB; i++) din_b[i] = din[i];
    end

    data_skew_buffer #(.DATA_WIDTH(W), .DATA_NUM(NA), .SKEW_STEP(SA)) u_a (
        .clk(clk), .rst(rst), .en_i(en), .flush_i(flush), .mode_i(mode_in),
        .data_in(din), .data_out(dout_a),
        .input_valid_i(v_in), .calc_done_i(c_in), .is_init_data_i(i_in),
        .input_valid_o(va), .calc_done_o(ca), .is_init_data_o(ia),
        .mode_o(ma), .busy_o(ba)
    );

    data_skew_buffer #(.DATA_WIDTH(W), .DATA_NUM(NB), .SKEW_STEP(SB)) u_b (
        .clk(clk), .rst(rst), .en_i(en), .flush_i(flush), .mode_i(mode_in),
        .data_in(din_b), .data_out(dout_b),
        .input_valid_i(v_in), .calc_done_i(c_in), .is_init_data_i(i_in),
        .input_valid_o(vb), .calc_done_o(cb), .is_init_data_o(ib),
        .mode_o(mb), .busy_o(bb)
    );

    // Reference model: a log of every beat accepted on an enabled edge.
    // A lane with delay d shows the beat accepted d-1 log entries ago; entries
    // older than 'base' were wiped by reset or flush and read as zero.
    int nchk = 0;
    int nfail = 0;
    int ecount = 0;
    int base = 1;
    logic signed [W-1:0] log_d [LOGN][NA];
    logic log_v [LOGN];
    logic log_c [LOGN];
    logic log_i [LOGN];
    logic mode_a_m = 1'b0;
    logic mode_b_m = 1'b0;

    function automatic logic signed [W-1:0] exp_data(input int lane, input int d);
        int idx;
        if (d == 0) return din[lane];
        idx = ecount - d + 1;
        if (idx < base) return '0;
        return log_d[idx][lane];
    endfunction

    function automatic logic exp_tag(input int which, input int d);
        int idx;
        idx = ecount - d + 1;
        if (idx < base) return 1'b0;
        case (which)
            0:       return log_v[idx];
            1:       return log_c[idx];
            default: return log_i[idx];
        endcase
    endfunction

    function automatic logic exp_busy(input int m);
        logic b;
        b = 1'b0;
        for (int d = 1; d <= m; d++) b |= exp_tag(0, d);
        return b;
    endfunction

    task automatic model_edge();
        logic ba_pre, bb_pre;
        if (rst) return;
        ba_pre = exp_busy(MA);
        bb_pre = exp_busy(MB);
        if (!ba_pre && !v_in && !flush) mode_a_m = mode_in;
        if (!bb_pre && !v_in && !flush) mode_b_m = mode_in;
        if (flush) begin
            base = ecount + 1;
        end else if (en) begin
            ecount++;
            for (int i = 0; i < NA; i++) log_d[ecount][i] = din[i];
            log_v[ecount] = v_in;
            log_c[ecount] = c_in;
            log_i[ecount] = i_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic chk_d(input string tag, input logic signed [W-1:0] obs, input logic signed [W-1:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NA; i++)
            chk_d($sformatf("a_lane%0d", i), dout_a[i], exp_data(i, mode_a_m ? (NA-1-i)*SA : i*SA));
        chk_b("a_valid", va, exp_tag(0, MA));
        chk_b("a_done",  ca, exp_tag(1, MA));
        chk_b("a_init",  ia, exp_tag(2, MA));
        chk_b("a_mode",  ma, mode_a_m);
        chk_b("a_busy",  ba, exp_busy(MA));
        for (int i = 0; i < NB; i++)
            chk_d($sformatf("b_lane%0d", i), dout_b[i], exp_data(i, mode_b_m ? (NB-1-i)*SB : i*SB));
        chk_b("b_valid", vb, exp_tag(0, MB));
        chk_b("b_done",  cb, exp_tag(1, MB));
        chk_b("b_init",  ib, exp_tag(2, MB));
        chk_b("b_mode",  mb, mode_b_m);
        chk_b("b_busy",  bb, exp_busy(MB));
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    task automatic zero_inputs();
        for (int i = 0; i < NA; i++) din[i] = '0;
        v_in = 1'b0;
        c_in = 1'b0;
        i_in = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic m);
        zero_inputs();
        en = 1'b1;
        flush = 1'b0;
        mode_in = m;
        for (int k = 0; k < n; k++) begin
            settle_check();
            tick();
        end
    endtask

    task automatic async_reset();
        rst = 1'b1;
        base = ecount + 1;
        mode_a_m = 1'b0;
        mode_b_m = 1'b0;
        settle_check();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        mode_in = 1'b0;
        zero_inputs();
        #1;
        check_all();
        chk_b("reset_mode_a", ma, 1'b0);
        chk_b("reset_busy_b", bb, 1'b0);
        tick();
        #1;
        rst = 1'b0;
        idle_cycles(2, 1'b0);

        // Skew on the 4-lane instance: single beat {10,20,30,40}.
        din[0] = 16'sd10; din[1] = 16'sd20; din[2] = 16'sd30; din[3] = 16'sd40;
        v_in = 1'b1; c_in = 1'b1;
        settle_check();
        chk_d("skew_l0_t0", dout_a[0], 16'sd10);
        tick();
        zero_inputs();
        settle_check();
        chk_d("skew_l1_t1", dout_a[1], 16'sd20);
        chk_b("skew_busy_t1", ba, 1'b1);
        tick();
        settle_check();
        chk_d("skew_l2_t2", dout_a[2], 16'sd30);
        chk_b("skew_valid_t2", va, 1'b0);
        tick();
        settle_check();
        chk_d("skew_l3_t3", dout_a[3], 16'sd40);
        chk_b("skew_valid_t3", va, 1'b1);
        chk_b("skew_done_t3", ca, 1'b1);
        chk_b("skew_busy_t3", ba, 1'b1);
        tick();
        settle_check();
        chk_b("skew_busy_t4", ba, 1'b0);
        chk_b("skew_valid_t4", va, 1'b0);
        idle_cycles(5, 1'b0);

        // Deskew: latch mode 1 while idle, then feed a skewed wavefront.
        idle_cycles(1, 1'b1);
        settle_check();
        chk_b("deskew_mode_a", ma, 1'b1);
        chk_b("deskew_mode_b", mb, 1'b1);
        for (int t = 0; t < NA; t++) begin
            zero_inputs();
            din[t] = 16'(100 * (t + 1));
            v_in = (t == 0);
            settle_check();
            if (t == NA - 1) begin
                for (int i = 0; i < NA; i++)
                    chk_d($sformatf("deskew_align%0d", i), dout_a[i], 16'(100 * (i + 1)));
            end
            tick();
        end
        idle_cycles(6, 1'b1);
        idle_cycles(2, 1'b0);
        chk_b("back_to_skew_b", mb, 1'b0);

        // Stall on the 3-lane/step-2 instance: beat, one more edge, 3 frozen edges.
        din[0] = 16'sd11; din[1] = 16'sd22; din[2] = -16'sd33; din[3] = 16'sd44;
        v_in = 1'b1; i_in = 1'b1;
        settle_check();
        tick();
        zero_inputs();
        for (int w = 2; w <= 7; w++) begin
            en = !(w >= 3 && w <= 5);
            settle_check();
            chk_b($sformatf("stall_busy_w%0d", w), bb, 1'b1);
            chk_b($sformatf("stall_valid_w%0d", w), vb, 1'b0);
            tick();
        end
        en = 1'b1;
        settle_check();
        chk_b("stall_valid_out", vb, 1'b1);
        chk_b("stall_init_out", ib, 1'b1);
        chk_d("stall_lane2_out", dout_b[2], -16'sd33);
        idle_cycles(6, 1'b0);

        // Flush with en low and two beats in flight.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NA; i++) din[i] = 16'(7 + k + i);
            v_in = 1'b1; c_in = 1'b1;
            settle_check();
            tick();
        end
        zero_inputs();
        en = 1'b0;
        flush = 1'b1;
        settle_check();
        tick();
        flush = 1'b0;
        settle_check();
        for (int i = 1; i < NA; i++) chk_d($sformatf("flush_a_lane%0d", i), dout_a[i], '0);
        chk_b("flush_busy_a", ba, 1'b0);
        chk_b("flush_busy_b", bb, 1'b0);
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle_check();
            chk_b("flush_no_done_a", ca, 1'b0);
            chk_b("flush_no_done_b", cb, 1'b0);
            tick();
        end

        // Mode change requested while a beat is in flight on the 4-lane instance.
        din[0] = 16'sd5;
        v_in = 1'b1;
        mode_in = 1'b1;
        settle_check();
        tick();
        zero_inputs();
        for (int k = 1; k <= 3; k++) begin
            settle_check();
            chk_b($sformatf("modebusy_hold%0d", k), ma, 1'b0);
            tick();
        end
        settle_check();
        chk_b("modebusy_idle", ba, 1'b0);
        chk_b("modebusy_still0", ma, 1'b0);
        tick();
        settle_check();
        chk_b("modebusy_switched", ma, 1'b1);

        // Async reset between edges with beats in flight (deskew mode active).
        idle_cycles(6, 1'b1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NA; i++) din[i] = 16'(-50 - k - i);
            v_in = 1'b1;
            settle_check();
            tick();
        end
        zero_inputs();
        rst = 1'b1;
        base = ecount + 1;
        mode_a_m = 1'b0;
        mode_b_m = 1'b0;
        #1;
        chk_b("arst_mode_a", ma, 1'b0);
        chk_b("arst_busy_a", ba, 1'b0);
        chk_b("arst_busy_b", bb, 1'b0);
        chk_d("arst_a_lane3", dout_a[3], '0);
        check_all();
        tick();
        rst = 1'b0;
        mode_in = 1'b0;
        din[0] = 16'sd1; din[1] = 16'sd2; din[2] = 16'sd3; din[3] = 16'sd4;
        v_in = 1'b1;
        settle_check();
        tick();
        zero_inputs();
        for (int k = 1; k <= 3; k++) begin
            settle_check();
            tick();
        end
        settle_check();
        chk_b("postrst_valid_a", va, 1'b0);
        idle_cycles(2, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NA; i++) din[i] = 16'($urandom);
            en      = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 24) == 0);
            v_in    = $urandom_range(0, 1) == 1;
            c_in    = $urandom_range(0, 1) == 1;
            i_in    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) mode_in = ~mode_in;
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                settle_check();
                tick();
            end
        end
        idle_cycles(4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
